nn_ctrl_queue_regs: RTL and testbench
=====================================

Name: nn_ctrl_queue_regs

Overview:
Parametrised successor of the accelerator's memory-mapped control register bank. The host writes a descriptor (offset, dest, numOps, cache-com and control fields) into staging registers, then rings a doorbell that pushes it into a descriptor FIFO. An issue state machine pops descriptors and hands them to the layer FSM through a begin/ready handshake, so the host can stage the next op while the current one runs. Addresses outside the register window pass through to the cache, as before.

Parameters:
DATA_W, 16, host and cache data width (>=16)
ADDR_W, 16, host and cache address width
BASE_ADDR, 16'h8000, first address of the 8-word register window
QUEUE_DEPTH, 4, descriptor FIFO depth; power of 2, range 2..128
CNT_W (localparam), clog2(QUEUE_DEPTH)+1, width of the queue occupancy count

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
we  in  1  host write enable
addr  in  ADDR_W  host address
wdata  in  DATA_W  host write data
rdata  out  DATA_W  host read data (combinational)
cache_rdata  in  DATA_W  cache read data
cache_addr  out  ADDR_W  equals addr
cache_wdata  out  DATA_W  equals wdata
cache_we  out  1  we AND addr outside the register window
fsm_ready  in  1  layer FSM idle / ready for next op
fsm_begin_op  out  1  one-cycle start pulse to the FSM
offset, dest, num_ops  out  DATA_W each  active descriptor words
cache_com_sel  out  2  active cachecom[3:2]
weight_not_index  out  1  active cachecom[1]
param_not_layer  out  1  active cachecom[0]
act_func_sel  out  2  active control[6:5]
write_reverse  out  1  active control[4]
weight_op_sel  out  2  active control[3:2]
index_op_sel  out  2  active control[1:0]
busy  out  1  issue FSM not in IDLE
irq  out  1  done_sticky AND irq_en

Behaviour:
Register map, relative to BASE_ADDR:
- +0 OFFSET, +1 DEST, +2 NUMOPS: staging registers, R/W, full DATA_W.
- +3 CACHECOM: 4 bits, R/W; upper read bits are 0.
- +4 CONTROL: 7 bits, R/W; upper read bits are 0.
- +5 DOORBELL: a write of any data pushes {staging regs} into the FIFO; reads return 0.
- +6 STATUS:
  - [CNT_W-1:0] queue count (RO)
  - [8] busy (RO)
  - [9] full (RO)
  - [10] overflow sticky (W1C)
  - [11] done sticky (W1C)
  - [15] irq_en (R/W)
  - all other bits read 0
- +7 DONE_COUNT: RO count of completed ops, wraps at 2^DATA_W; any write clears it to 0.
- Any other address: rdata = cache_rdata and cache_we = we.
- Writes to the window never reach the cache.

Staging registers are independent of the active descriptor. Writing them never disturbs a running op. This block has no critical lockout.

FIFO:
- A doorbell while full drops the descriptor and sets overflow; count is unchanged.
- Push and pop in the same cycle leave count unchanged.
- The pushed value is the staging contents before that edge.

Issue FSM, registered:
- IDLE: if count>0 and fsm_ready=1, pop into the active registers, drive fsm_begin_op=1 for one cycle, and go to ACK.
- ACK: wait for fsm_ready=0, then go to RUN. fsm_begin_op is 0 from here on.
- RUN: when fsm_ready=1, the op is complete: DONE_COUNT+1, set done_sticky, go to IDLE.
- A new issue can occur at the next edge after returning to IDLE.

Latency:
- Doorbell sampled at edge E into an empty FIFO with the FSM idle and ready.
- Count reads 1 after E.
- The active outputs update and fsm_begin_op rises after E+1, and falls after E+2.

Sticky-bit priority:
- Set and W1C in the same cycle: set wins.
- DONE_COUNT write and completion in the same cycle: the clear wins, result 0.

Reset (async, rst_n=0, including mid-op):
- All registers, FIFO pointers and count, and active outputs go to 0.
- Sticky bits and irq_en go to 0; FSM goes to IDLE.
- fsm_begin_op=0, busy=0, irq=0.
- Queued descriptors are discarded.

Test Plan:
- Reset, then read +0..+7 -> all 0. Write 0x1234 to 0x9000 -> cache_we=1. Write 0x5555 to 0x8000 -> cache_we=0, OFFSET reads 0x5555.
- Stage offset=0x10, dest=0x20, numops=3, cachecom=0xB, control=0x55, doorbell, fsm_ready=1 -> fsm_begin_op high for exactly 1 cycle, 2 edges after the doorbell. Outputs: offset=0x10, cache_com_sel=2, weight_not_index=1, param_not_layer=1, act_func_sel=2, write_reverse=1, weight_op_sel=1, index_op_sel=1.
- Hold fsm_ready=0 and ring 5 doorbells with QUEUE_DEPTH=4 -> STATUS count=4, full=1, overflow=1. Write 0x0400 to STATUS -> overflow clears.
- Queue 3 descriptors and have a model FSM drop fsm_ready for 4 cycles each -> 3 pulses in FIFO order; DONE_COUNT=3; done sticky=1; with irq_en=1, irq=1.
- While op A runs, rewrite staging and ring a doorbell -> op A outputs stay unchanged until A completes; then B issues.
- Assert rst_n=0 in RUN with 2 queued -> all outputs 0 immediately, count=0, and no pulse after release.

Source files
------------

// File: rtl/nn_ctrl_queue_regs.sv
// Memory-mapped control register bank with a doorbell-fed descriptor FIFO and
// an issue FSM that hands queued ops to the layer FSM over a begin/ready handshake.
module nn_ctrl_queue_regs #(
    parameter int unsigned          DATA_W      = 16,
    parameter int unsigned          ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = 16'h8000,
    parameter int unsigned          QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              cache_we,
    input  logic              fsm_ready,
    output logic              fsm_begin_op,
    output logic [DATA_W-1:0] offset,
    output logic [DATA_W-1:0] dest,
    output logic [DATA_W-1:0] num_ops,
    output logic [1:0]        cache_com_sel,
    output logic              weight_not_index,
    output logic              param_not_layer,
    output logic [1:0]        act_func_sel,
    output logic              write_reverse,
    output logic [1:0]        weight_op_sel,
    output logic [1:0]        index_op_sel,
    output logic              busy,
    output logic              irq
);

    localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int unsigned DESC_W = 3 * DATA_W + 11;

    localparam logic [2:0] RegOffset   = 3'd0;
    localparam logic [2:0] RegDest     = 3'd1;
    localparam logic [2:0] RegNumOps   = 3'd2;
    localparam logic [2:0] RegCacheCom = 3'd3;
    localparam logic [2:0] RegControl  = 3'd4;
    localparam logic [2:0] RegDoorbell = 3'd5;
    localparam logic [2:0] RegStatus   = 3'd6;
    localparam logic [2:0] RegDoneCnt  = 3'd7;

    typedef enum logic [1:0] {StIdle, StAck, StRun} state_e;

    // Address decode
    logic [ADDR_W-1:0] rel_addr;
    logic              in_win;
    logic [2:0]        reg_sel;
    logic              wr_win;

    assign rel_addr = addr - BASE_ADDR;
    assign in_win   = (rel_addr < ADDR_W'(8));
    assign reg_sel  = rel_addr[2:0];
    assign wr_win   = we & in_win;

    assign cache_addr  = addr;
    assign cache_wdata = wdata;
    assign cache_we    = we & ~in_win;

    // Staging registers
    logic [DATA_W-1:0] stg_offset_q, stg_dest_q, stg_num_ops_q;
    logic [3:0]        stg_cache_com_q;
    logic [6:0]        stg_control_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_offset_q    <= '0;
            stg_dest_q      <= '0;
            stg_num_ops_q   <= '0;
            stg_cache_com_q <= '0;
            stg_control_q   <= '0;
        end else if (wr_win) begin
            case (reg_sel)
                RegOffset:   stg_offset_q    <= wdata;
                RegDest:     stg_dest_q      <= wdata;
                RegNumOps:   stg_num_ops_q   <= wdata;
                RegCacheCom: stg_cache_com_q <= wdata[3:0];
                RegControl:  stg_control_q   <= wdata[6:0];
                default: ;
            endcase
        end
    end

    // Descriptor FIFO
    logic [DESC_W-1:0] fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              full;
    logic              push_req, push, pop;
    logic              ovf_set;

    assign full     = (count_q == CNT_W'(QUEUE_DEPTH));
    assign push_req = wr_win & (reg_sel == RegDoorbell);
    assign push     = push_req & ~full;
    assign ovf_set  = push_req & full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= {stg_offset_q, stg_dest_q, stg_num_ops_q,
                                       stg_cache_com_q, stg_control_q};
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Issue FSM
    state_e state_q, state_d;
    logic   begin_q;
    logic   done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            begin_q <= 1'b0;
        end else begin
            state_q <= state_d;
            begin_q <= pop;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if ((count_q != '0) && fsm_ready) begin
                    pop     = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!fsm_ready) state_d = StRun;
            end
            StRun: begin
                if (fsm_ready) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Active descriptor, loaded only on issue so staging writes never disturb it
    logic [DATA_W-1:0] act_offset_q, act_dest_q, act_num_ops_q;
    logic [3:0]        act_cache_com_q;
    logic [6:0]        act_control_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_offset_q    <= '0;
            act_dest_q      <= '0;
            act_num_ops_q   <= '0;
            act_cache_com_q <= '0;
            act_control_q   <= '0;
        end else if (pop) begin
            {act_offset_q, act_dest_q, act_num_ops_q, act_cache_com_q, act_control_q}
                <= fifo_mem[rd_ptr_q];
        end
    end

    // Status, sticky bits and completion counter
    logic              ovf_q, done_sticky_q, irq_en_q;
    logic [DATA_W-1:0] done_cnt_q;
    logic              wr_status;

    assign wr_status = wr_win & (reg_sel == RegStatus);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q         <= 1'b0;
            done_sticky_q <= 1'b0;
            irq_en_q      <= 1'b0;
            done_cnt_q    <= '0;
        end else begin
            // Set takes priority over W1C
            if (ovf_set)                     ovf_q <= 1'b1;
            else if (wr_status && wdata[10]) ovf_q <= 1'b0;
            if (done)                        done_sticky_q <= 1'b1;
            else if (wr_status && wdata[11]) done_sticky_q <= 1'b0;
            if (wr_status)                   irq_en_q <= wdata[15];
            // Clear takes priority over a coincident completion
            if (wr_win && (reg_sel == RegDoneCnt)) done_cnt_q <= '0;
            else if (done)                         done_cnt_q <= done_cnt_q + DATA_W'(1);
        end
    end

    always_comb begin
        rdata = '0;
        if (in_win) begin
            case (reg_sel)
                RegOffset:   rdata = stg_offset_q;
                RegDest:     rdata = stg_dest_q;
                RegNumOps:   rdata = stg_num_ops_q;
                RegCacheCom: rdata[3:0] = stg_cache_com_q;
                RegControl:  rdata[6:0] = stg_control_q;
                RegStatus: begin
                    rdata[CNT_W-1:0] = count_q;
                    rdata[8]         = busy;
                    rdata[9]         = full;
                    rdata[10]        = ovf_q;
                    rdata[11]        = done_sticky_q;
                    rdata[15]        = irq_en_q;
                end
                RegDoneCnt:  rdata = done_cnt_q;
                default:     rdata = '0;
            endcase
        end else begin
            rdata = cache_rdata;
        end
    end

    assign fsm_begin_op     = begin_q;
    assign offset           = act_offset_q;
    assign dest             = act_dest_q;
    assign num_ops          = act_num_ops_q;
    assign cache_com_sel    = act_cache_com_q[3:2];
    assign weight_not_index = act_cache_com_q[1];
    assign param_not_layer  = act_cache_com_q[0];
    assign act_func_sel     = act_control_q[6:5];
    assign write_reverse    = act_control_q[4];
    assign weight_op_sel    = act_control_q[3:2];
    assign index_op_sel     = act_control_q[1:0];
    assign busy             = (state_q != StIdle);
    assign irq              = done_sticky_q & irq_en_q;

endmodule

// File: tb/tb_nn_ctrl_queue_regs.sv
// Directed self-checking bench for nn_ctrl_queue_regs with default parameters.
module tb_nn_ctrl_queue_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic [15:0] cache_rdata = '0;
    logic [15:0] cache_addr;
    logic [15:0] cache_wdata;
    logic        cache_we;
    logic        fsm_ready = 1'b0;
    logic        fsm_begin_op;
    logic [15:0] offset, dest, num_ops;
    logic [1:0]  cache_com_sel, act_func_sel, weight_op_sel, index_op_sel;
    logic        weight_not_index, param_not_layer, write_reverse, busy, irq;

    int checks = 0;
    int failures = 0;

    nn_ctrl_queue_regs dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .cache_rdata(cache_rdata), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_we(cache_we), .fsm_ready(fsm_ready), .fsm_begin_op(fsm_begin_op),
        .offset(offset), .dest(dest), .num_ops(num_ops), .cache_com_sel(cache_com_sel),
        .weight_not_index(weight_not_index), .param_not_layer(param_not_layer),
        .act_func_sel(act_func_sel), .write_reverse(write_reverse),
        .weight_op_sel(weight_op_sel), .index_op_sel(index_op_sel), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        we = 1'b1;
        addr = a;
        wdata = d;
        @(negedge clk);
        we = 1'b0;
        addr = '0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        we = 1'b0;
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            rd(16'h8000 + 16'(i), d);
            checks++;
            if (d !== 16'h0) begin
                failures++;
                $display("FAIL reset_read[%0d] got=%h want=0000", i, d);
            end
        end
        checks++;
        if (fsm_begin_op !== 1'b0 || busy !== 1'b0 || irq !== 1'b0 || offset !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got begin=%b busy=%b irq=%b off=%h want 0", fsm_begin_op,
                     busy, irq, offset);
        end
    endtask

    task automatic test_window();
        logic [15:0] d;
        @(negedge clk);
        we = 1'b1; addr = 16'h9000; wdata = 16'h1234;
        #1;
        checks++;
        if (cache_we !== 1'b1 || cache_addr !== 16'h9000 || cache_wdata !== 16'h1234) begin
            failures++;
            $display("FAIL cache_pass got we=%b a=%h d=%h want 1 9000 1234", cache_we,
                     cache_addr, cache_wdata);
        end
        addr = 16'h8000; wdata = 16'h5555;
        #1;
        checks++;
        if (cache_we !== 1'b0) begin
            failures++;
            $display("FAIL window_cache_we got=%b want=0", cache_we);
        end
        @(negedge clk);
        we = 1'b0;
        rd(16'h8000, d);
        checks++;
        if (d !== 16'h5555) begin
            failures++;
            $display("FAIL offset_readback got=%h want=5555", d);
        end
        cache_rdata = 16'hBEEF;
        rd(16'h9000, d);
        checks++;
        if (d !== 16'hBEEF) begin
            failures++;
            $display("FAIL cache_read got=%h want=beef", d);
        end
        wr(16'h8003, 16'hFFFF);
        rd(16'h8003, d);
        checks++;
        if (d !== 16'h000F) begin
            failures++;
            $display("FAIL cachecom_mask got=%h want=000f", d);
        end
        wr(16'h8004, 16'hFFFF);
        rd(16'h8004, d);
        checks++;
        if (d !== 16'h007F) begin
            failures++;
            $display("FAIL control_mask got=%h want=007f", d);
        end
    endtask

    task automatic test_latency();
        logic [15:0] d;
        apply_reset();
        fsm_ready = 1'b1;
        wr(16'h8000, 16'h0010);
        wr(16'h8001, 16'h0020);
        wr(16'h8002, 16'h0003);
        wr(16'h8003, 16'h000B);
        wr(16'h8004, 16'h0055);
        wr(16'h8005, 16'h0000);
        rd(16'h8006, d);
        checks++;
        if (d !== 16'h0001 || fsm_begin_op !== 1'b0) begin
            failures++;
            $display("FAIL latency_e status=%h begin=%b want 0001 0", d, fsm_begin_op);
        end
        @(negedge clk);
        checks++;
        if (fsm_begin_op !== 1'b1 || offset !== 16'h10 || dest !== 16'h20 || num_ops !== 16'h3)
        begin
            failures++;
            $display("FAIL latency_issue begin=%b off=%h dst=%h n=%h want 1 10 20 3",
                     fsm_begin_op, offset, dest, num_ops);
        end
        checks++;
        if ({cache_com_sel, weight_not_index, param_not_layer, act_func_sel, write_reverse,
             weight_op_sel, index_op_sel} !== {2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1, 2'd1}) begin
            failures++;
            $display("FAIL decode_fields got cc=%0d wni=%b pnl=%b af=%0d wr=%b wo=%0d io=%0d",
                     cache_com_sel, weight_not_index, param_not_layer, act_func_sel,
                     write_reverse, weight_op_sel, index_op_sel);
        end
        fsm_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (fsm_begin_op !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pulse_width begin=%b busy=%b want 0 1", fsm_begin_op, busy);
        end
        @(negedge clk);
        fsm_ready = 1'b1;
        @(negedge clk);
        rd(16'h8007, d);
        checks++;
        if (d !== 16'h0001) begin
            failures++;
            $display("FAIL done_count_one got=%h want=0001", d);
        end
        rd(16'h8006, d);
        checks++;
        if (d !== 16'h0800) begin
            failures++;
            $display("FAIL done_sticky got=%h want=0800", d);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        apply_reset();
        fsm_ready = 1'b0;
        repeat (5) wr(16'h8005, 16'h0000);
        rd(16'h8006, d);
        checks++;
        if (d !== 16'h0604) begin
            failures++;
            $display("FAIL overflow_status got=%h want=0604", d);
        end
        wr(16'h8006, 16'h0400);
        rd(16'h8006, d);
        checks++;
        if (d !== 16'h0204) begin
            failures++;
            $display("FAIL overflow_w1c got=%h want=0204", d);
        end
    endtask

    task automatic test_fifo_order();
        logic [15:0] d;
        int pulses = 0;
        int timer = 0;
        logic prev_begin = 1'b0;
        logic finished = 1'b0;
        apply_reset();
        fsm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(16'h8000, 16'h00A1 + 16'(i));
            wr(16'h8005, 16'h0000);
        end
        wr(16'h8006, 16'h8000);
        rd(16'h8006, d);
        checks++;
        if (d !== 16'h8003 || irq !== 1'b0) begin
            failures++;
            $display("FAIL queued_status got=%h irq=%b want 8003 0", d, irq);
        end
        fsm_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            @(negedge clk);
            if (fsm_begin_op) begin
                checks++;
                if (prev_begin || offset !== 16'h00A1 + 16'(pulses)) begin
                    failures++;
                    $display("FAIL order[%0d] off=%h prev_begin=%b want off=%h single", pulses,
                             offset, prev_begin, 16'h00A1 + 16'(pulses));
                end
                pulses++;
                fsm_ready = 1'b0;
                timer = 4;
            end else if (timer > 0) begin
                timer--;
                if (timer == 0) fsm_ready = 1'b1;
            end
            prev_begin = fsm_begin_op;
            if (pulses == 3 && fsm_ready && !busy) finished = 1'b1;
        end
        checks++;
        if (!finished || pulses != 3) begin
            failures++;
            $display("FAIL order_timeout pulses=%0d want=3", pulses);
        end
        rd(16'h8007, d);
        checks++;
        if (d !== 16'h0003) begin
            failures++;
            $display("FAIL done_count_three got=%h want=0003", d);
        end
        rd(16'h8006, d);
        checks++;
        if (d !== 16'h8800 || irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_status got=%h irq=%b want 8800 1", d, irq);
        end
        wr(16'h8007, 16'h1234);
        rd(16'h8007, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL done_count_clear got=%h want=0000", d);
        end
    endtask

    task automatic test_back_to_back();
        logic seen = 1'b0;
        apply_reset();
        fsm_ready = 1'b1;
        wr(16'h8000, 16'h0111);
        wr(16'h8005, 16'h0000);
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = fsm_begin_op;
        end
        fsm_ready = 1'b0;
        wr(16'h8000, 16'h0222);
        wr(16'h8005, 16'h0000);
        checks++;
        if (!seen || offset !== 16'h0111 || busy !== 1'b1) begin
            failures++;
            $display("FAIL active_stable seen=%b off=%h busy=%b want 1 0111 1", seen, offset,
                     busy);
        end
        seen = 1'b0;
        fsm_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = fsm_begin_op;
        end
        checks++;
        if (!seen || offset !== 16'h0222) begin
            failures++;
            $display("FAIL second_issue seen=%b off=%h want 1 0222", seen, offset);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] d;
        logic seen = 1'b0;
        apply_reset();
        fsm_ready = 1'b1;
        wr(16'h8000, 16'h0077);
        wr(16'h8005, 16'h0000);
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = fsm_begin_op;
        end
        fsm_ready = 1'b0;
        wr(16'h8005, 16'h0000);
        wr(16'h8005, 16'h0000);
        rd(16'h8006, d);
        checks++;
        if (!seen || d !== 16'h0102) begin
            failures++;
            $display("FAIL pre_reset seen=%b status=%h want 1 0102", seen, d);
        end
        #2 rst_n = 1'b0;
        #1;
        rd(16'h8006, d);
        checks++;
        if (d !== 16'h0 || offset !== 16'h0 || busy !== 1'b0 || fsm_begin_op !== 1'b0 ||
            irq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset status=%h off=%h busy=%b begin=%b irq=%b want 0", d,
                     offset, busy, fsm_begin_op, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fsm_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (fsm_begin_op) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL no_pulse_after_reset got=1 want=0");
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_latency();
        test_overflow();
        test_fifo_order();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
